// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the external memory port, sharing it between the core
// and the OAM DMA engine (FF46 start register, source page -> FE00 copy).
// Ports: clk, rst (async, active-high); cpu_addr/rd/wr/wdata -> cpu_rdata;
//        bus_addr/rd/wr/wdata <- bus_rdata memory port; dma_active status.
module oam_dma_arbiter #(
  parameter int DMA_LEN     = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  localparam int IW = $clog2(DMA_LEN);
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DMA_LEN - 1);
  localparam logic [DW-1:0] DLY_LAST =
    DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    READ,
    WRITE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    dma_src_hi, src_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] dly_cnt, dly_n;
  logic [7:0]    byte_buf, buf_n;

  logic       cpu_acc;
  logic       reg_hit;
  logic       reg_wr;
  logic       hram;
  logic       dma_phase;
  logic       stall;
  logic [7:0] src_hi;

  assign cpu_acc   = cpu_rd | cpu_wr;
  assign reg_hit   = cpu_acc && (cpu_addr == 16'hFF46);
  assign reg_wr    = cpu_wr && (cpu_addr == 16'hFF46);
  assign hram      = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
  assign dma_phase = (state == READ) || (state == WRITE);
  // HRAM traffic wins the port; the DMA op is simply retried next cycle.
  assign stall     = dma_phase && cpu_acc && hram;
  assign dma_active = (state != IDLE);

  // E0-FF source pages alias C0-DF.
  assign src_hi = (dma_src_hi[7:5] == 3'b111) ?
                  (dma_src_hi & 8'hDF) : dma_src_hi;

  always_comb begin
    bus_addr  = cpu_addr;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = cpu_wdata;
    cpu_rdata = bus_rdata;
    if (dma_phase && !stall) begin
      cpu_rdata = 8'hFF;
      if (state == READ) begin
        bus_addr = {src_hi, 8'(idx)};
        bus_rd   = 1'b1;
      end else begin
        bus_addr  = 16'hFE00 + 16'(idx);
        bus_wr    = 1'b1;
        bus_wdata = byte_buf;
      end
    end else if (!reg_hit) begin
      bus_rd = cpu_rd & ~cpu_wr;
      bus_wr = cpu_wr;
    end
    if (reg_hit) cpu_rdata = dma_src_hi;
  end

  always_comb begin
    state_n = state;
    src_n   = dma_src_hi;
    idx_n   = idx;
    dly_n   = dly_cnt;
    buf_n   = byte_buf;
    unique case (state)
      IDLE: state_n = IDLE;
      DELAY: begin
        if (dly_cnt == DLY_LAST) begin
          state_n = READ;
          dly_n   = '0;
        end else begin
          dly_n = dly_cnt + DW'(1);
        end
      end
      READ: begin
        if (!stall) begin
          buf_n   = bus_rdata;
          state_n = WRITE;
        end
      end
      WRITE: begin
        if (!stall) begin
          if (idx == IDX_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
          end else begin
            state_n = READ;
            idx_n   = idx + IW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // A start write overrides whatever the engine was about to do next.
    if (reg_wr) begin
      src_n   = cpu_wdata;
      idx_n   = '0;
      dly_n   = '0;
      state_n = (START_DELAY == 0) ? READ : DELAY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dma_src_hi <= 8'hFF;
      idx        <= '0;
      dly_cnt    <= '0;
      byte_buf   <= '0;
    end else begin
      state      <= state_n;
      dma_src_hi <= src_n;
      idx        <= idx_n;
      dly_cnt    <= dly_n;
      byte_buf   <= buf_n;
    end
  end

  no_rd_wr_overlap: assert property (
    @(posedge clk) disable iff (rst) !(cpu_rd && cpu_wr));

endmodule
